regfile_wb_sink: RTL and testbench
==================================

Name: regfile_wb_sink

Overview:
- Integer register file that consumes the write-back interface (wb_wd / wb_wreg / wb_wdata) and serves the decode stage's two operand read ports.
- Sits at the receiving end of write-back.
- Provides same-cycle write-to-read bypass so the single-cycle datapath never reads a stale operand.
- Provides a debug read port and a retired-write counter for the bench.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W
- CNT_W, 32, width of the retired-write counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- wb_wd  input  ADDR_W  write-back destination register index
- wb_wreg  input  1  write-back write enable
- wb_wdata  input  DATA_W  write-back data
- reg1_read  input  1  read enable, port 1
- reg1_addr  input  ADDR_W  read index, port 1
- reg1_data  output  DATA_W  read data, port 1 (combinational)
- reg2_read  input  1  read enable, port 2
- reg2_addr  input  ADDR_W  read index, port 2
- reg2_data  output  DATA_W  read data, port 2 (combinational)
- dbg_addr  input  ADDR_W  debug read index; no bypass
- dbg_data  output  DATA_W  debug read data (combinational, stored value only)
- wr_count  output  CNT_W  number of committed writes to x1..x31 since reset (registered)

Behaviour:
- Storage: NUM_REGS x DATA_W flops. x0 is hardwired to zero: never written, always reads 0 on every port.
- Reset (rst == 0 at a rising edge):
  - All storage entries clear to 0.
  - wr_count clears to 0.
  - Any write-back presented in that cycle is discarded.
- Reset-held outputs: while rst == 0, reg1_data, reg2_data and dbg_data are forced to 0 combinationally.
- Write:
  - Condition: rst == 1, wb_wreg == 1 and wb_wd != 0.
  - Effect at the rising edge: mem[wb_wd] <= wb_wdata, and wr_count <= wr_count + 1.
  - Any other combination leaves storage and wr_count unchanged.
- Write latency: the written value is visible on dbg_data from the cycle after the edge. Read ports see it in the same cycle through the bypass.
- Read port n (n = 1, 2), priority order:
  - rst == 0 -> 0
  - regn_read == 0 -> 0
  - regn_addr == 0 -> 0
  - wb_wreg == 1 and wb_wd == regn_addr -> wb_wdata (bypass)
  - otherwise -> mem[regn_addr]
- Both read ports are independent. Both may address the same register and may bypass simultaneously.
- Debug port: returns mem[dbg_addr] with no bypass. Returns 0 for dbg_addr == 0 or rst == 0.
- wr_count wraps modulo 2**CNT_W; there is no saturation.
- Reset mid-operation: a write coincident with a reset edge is dropped. Reads in that cycle return 0.
- Writes to x0 do not increment wr_count.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- Reset then dump: hold rst = 0 for 2 cycles, release, sweep dbg_addr 0..31 -> every dbg_data = 0, wr_count = 0.
- Write then read:
  - Write x5 = 32'hDEADBEEF (wb_wreg = 1, wb_wd = 5) for one cycle.
  - Next cycle, reg1_read = 1, reg1_addr = 5 -> reg1_data = 32'hDEADBEEF, dbg_data (dbg_addr = 5) = 32'hDEADBEEF, wr_count = 1.
- Same-cycle bypass:
  - x7 holds 32'h11111111.
  - In one cycle present wb_wd = 7, wb_wdata = 32'h22222222, wb_wreg = 1, with reg1_addr = reg2_addr = 7 and both reads enabled.
  - Same cycle -> reg1_data = reg2_data = 32'h22222222, dbg_data (addr 7) = 32'h11111111.
  - Next cycle -> dbg_data = 32'h22222222.
- x0 protection: write wb_wd = 0, wb_wdata = 32'hFFFFFFFF, wb_wreg = 1 -> reg1_data (addr 0, read = 1) = 0 in the same and next cycle; wr_count unchanged.
- Read enable gating: x3 = 32'h0000ABCD, reg2_read = 0, reg2_addr = 3 -> reg2_data = 0. Raise reg2_read = 1 -> reg2_data = 32'h0000ABCD.
- Reset mid-stream:
  - After writes x1 = 1 and x2 = 2 (wr_count = 2), assert rst = 0 in the same cycle as a write x4 = 32'h44.
  - After release -> x1, x2 and x4 all read 0, wr_count = 0.
- Counter wrap: with CNT_W = 4, perform 17 writes to x9 -> wr_count = 1.

Source files
------------

// File: rtl/regfile_wb_sink.sv
// Integer register file at the write-back sink.
// Two bypassed operand ports, one raw debug port, retired-write counter.
module regfile_wb_sink #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              reg1_read,
  input  logic [ADDR_W-1:0] reg1_addr,
  output logic [DATA_W-1:0] reg1_data,
  input  logic              reg2_read,
  input  logic [ADDR_W-1:0] reg2_addr,
  output logic [DATA_W-1:0] reg2_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_en;

  assign wr_en = wb_wreg && (wb_wd != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
      wr_count <= '0;
    end else if (wr_en) begin
      mem[wb_wd] <= wb_wdata;
      wr_count   <= wr_count + CNT_W'(1);
    end
  end

  // x0 is never written, but the port muxes still force it to zero
  function automatic logic [DATA_W-1:0] rd_port(
    input logic              en,
    input logic [ADDR_W-1:0] addr
  );
    logic [DATA_W-1:0] d;
    d = '0;
    if (!rst || !en || addr == '0)
      d = '0;
    else if (wb_wreg && wb_wd == addr)
      d = wb_wdata;
    else
      d = mem[addr];
    return d;
  endfunction

  always_comb begin
    reg1_data = rd_port(reg1_read, reg1_addr);
    reg2_data = rd_port(reg2_read, reg2_addr);
  end

  always_comb begin
    dbg_data = '0;
    if (rst && dbg_addr != '0)
      dbg_data = mem[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench for regfile_wb_sink.
// Second instance with a 4-bit counter covers wrap-around.
module tb_regfile_wb_sink;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        reg1_read, reg2_read;
  logic [4:0]  reg1_addr, reg2_addr, dbg_addr;
  logic [31:0] reg1_data, reg2_data, dbg_data, wr_count;
  logic [31:0] r1_b, r2_b, dbg_b;
  logic [3:0]  cnt_b;

  regfile_wb_sink dut (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .reg1_read(reg1_read), .reg1_addr(reg1_addr), .reg1_data(reg1_data),
    .reg2_read(reg2_read), .reg2_addr(reg2_addr), .reg2_data(reg2_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  regfile_wb_sink #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .reg1_read(reg1_read), .reg1_addr(reg1_addr), .reg1_data(r1_b),
    .reg2_read(reg2_read), .reg2_addr(reg2_addr), .reg2_data(r2_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dbg;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
    bit          cnt_known;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  bit [31:0]       mem_m [32];
  longint unsigned cnt_m = 0;
  bit              known = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("reg1_data", reg1_data, e.r1);
      chk("reg2_data", reg2_data, e.r2);
      chk("dbg_data", dbg_data, e.dbg);
      chk("b_reg1_data", r1_b, e.r1);
      chk("b_dbg_data", dbg_b, e.dbg);
      if (e.cnt_known) begin
        chk("wr_count", wr_count, e.cnt);
        chk("wr_count4", {28'd0, cnt_b}, {28'd0, e.cnt4});
      end
    end
  end

  function automatic bit [31:0] port_model(
    input bit r, input bit w, input bit [4:0] wd, input bit [31:0] wdat,
    input bit en, input bit [4:0] a);
    if (!r || !en || a == 0) return 32'd0;
    if (w && wd == a) return wdat;
    return mem_m[a];
  endfunction

  task automatic step(
    input bit r, input bit w, input bit [4:0] wd, input bit [31:0] wdat,
    input bit e1, input bit [4:0] a1, input bit e2, input bit [4:0] a2,
    input bit [4:0] da);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; wb_wreg = w; wb_wd = wd; wb_wdata = wdat;
    reg1_read = e1; reg1_addr = a1;
    reg2_read = e2; reg2_addr = a2;
    dbg_addr = da;
    e.r1 = port_model(r, w, wd, wdat, e1, a1);
    e.r2 = port_model(r, w, wd, wdat, e2, a2);
    e.dbg = (!r || da == 0) ? 32'd0 : mem_m[da];
    e.cnt = 32'(cnt_m);
    e.cnt4 = 4'(cnt_m % 16);
    e.cnt_known = known;
    q.push_back(e);
    if (!r) begin
      foreach (mem_m[i]) mem_m[i] = 32'd0;
      cnt_m = 0;
      known = 1;
    end else if (w && wd != 0) begin
      mem_m[wd] = wdat;
      cnt_m++;
    end
  endtask

  task automatic wr(input bit [4:0] wd, input bit [31:0] d);
    step(1, 1, wd, d, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 1, 5'd6, 32'h66, 1, 6, 1, 6, 6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 0; wb_wreg = 0; wb_wd = 0; wb_wdata = 0;
    reg1_read = 0; reg1_addr = 0; reg2_read = 0; reg2_addr = 0;
    dbg_addr = 0;
    foreach (mem_m[i]) mem_m[i] = 32'd0;

    do_reset();
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 5'(i));

    wr(5, 32'hDEADBEEF);
    step(1, 0, 0, 0, 1, 5, 0, 0, 5);

    wr(7, 32'h11111111);
    step(1, 1, 7, 32'h22222222, 1, 7, 1, 7, 7);
    step(1, 0, 0, 0, 1, 7, 1, 7, 7);

    step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1, 0, 0);

    wr(3, 32'h0000ABCD);
    step(1, 0, 0, 0, 0, 0, 0, 3, 3);
    step(1, 0, 0, 0, 0, 0, 1, 3, 3);

    do_reset();
    wr(1, 32'd1);
    wr(2, 32'd2);
    step(1, 0, 0, 0, 1, 1, 1, 2, 2);
    step(0, 1, 4, 32'h44, 1, 4, 1, 4, 4);
    step(1, 0, 0, 0, 1, 1, 1, 2, 4);
    step(1, 0, 0, 0, 1, 4, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 17; i++)
      wr(9, $urandom);
    step(1, 0, 0, 0, 1, 9, 0, 0, 9);

    for (int i = 0; i < 400; i++) begin
      bit [4:0] wd, a1, a2;
      wd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 31));
      step($urandom_range(0, 49) != 0, 1'($urandom), wd, $urandom,
           1'($urandom), a1, 1'($urandom), a2, 5'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
